// File: rtl/sfx_pkg.sv
// Shared encodings and per-effect beep sequence constants for the sound-effect arbiter.
package sfx_pkg;

    typedef enum logic [1:0] {
        SFX_NONE   = 2'd0,
        SFX_START  = 2'd1,
        SFX_FINISH = 2'd2,
        SFX_CRASH  = 2'd3
    } sfx_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } sfx_state_t;

    localparam int unsigned MS_W   = 9;
    localparam int unsigned BEEP_W = 3;

    localparam logic [MS_W-1:0]   START_ON_MS   = 9'd100;
    localparam logic [MS_W-1:0]   START_OFF_MS  = 9'd100;
    localparam logic [BEEP_W-1:0] START_BEEPS   = 3'd3;
    localparam logic [MS_W-1:0]   FINISH_ON_MS  = 9'd60;
    localparam logic [MS_W-1:0]   FINISH_OFF_MS = 9'd40;
    localparam logic [BEEP_W-1:0] FINISH_BEEPS  = 3'd4;
    localparam logic [MS_W-1:0]   CRASH_ON_MS   = 9'd500;
    localparam logic [MS_W-1:0]   CRASH_OFF_MS  = 9'd0;
    localparam logic [BEEP_W-1:0] CRASH_BEEPS   = 3'd1;

    function automatic logic [MS_W-1:0] on_ms_of(input sfx_id_t id);
        case (id)
            SFX_START:  return START_ON_MS;
            SFX_FINISH: return FINISH_ON_MS;
            SFX_CRASH:  return CRASH_ON_MS;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [MS_W-1:0] off_ms_of(input sfx_id_t id);
        case (id)
            SFX_START:  return START_OFF_MS;
            SFX_FINISH: return FINISH_OFF_MS;
            SFX_CRASH:  return CRASH_OFF_MS;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [BEEP_W-1:0] beeps_of(input sfx_id_t id);
        case (id)
            SFX_START:  return START_BEEPS;
            SFX_FINISH: return FINISH_BEEPS;
            SFX_CRASH:  return CRASH_BEEPS;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave tone generator: toggles every half_period clocks while running,
// restarts high with a cleared counter on restart.
module sfx_tone_gen #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             run,
    input  logic [CNT_W:0]   half_period,
    output logic             tone
);

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_last;

    assign cnt_last = (({1'b0, cnt_q} + (CNT_W+1)'(1)) == half_period);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tone  <= 1'b0;
        end else if (restart) begin
            cnt_q <= '0;
            tone  <= 1'b1;
        end else if (run) begin
            if (cnt_last) begin
                cnt_q <= '0;
                tone  <= ~tone;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sfx_audio_arbiter.sv
// Shares the PWM audio pins between song passthrough and three edge-triggered
// beep sequences (CRASH > FINISH > START), with preemption by higher priority.
module sfx_audio_arbiter
    import sfx_pkg::*;
#(
    parameter int unsigned MS_TICKS  = 100000,
    parameter int unsigned HP_START  = 50000,
    parameter int unsigned HP_FINISH = 25000,
    parameter int unsigned HP_CRASH  = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       start_en,
    input  logic       crash_en,
    input  logic       finish_en,
    input  logic       song_pwm,
    input  logic       song_aud_on,
    output logic       pwm,
    output logic       aud_on,
    output logic       sfx_busy,
    output logic [1:0] sfx_id
);

    localparam int unsigned HP_MAX_SF = (HP_START > HP_FINISH) ? HP_START : HP_FINISH;
    localparam int unsigned HP_MAX    = (HP_MAX_SF > HP_CRASH) ? HP_MAX_SF : HP_CRASH;
    localparam int unsigned PW        = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam int unsigned TW        = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(MS_TICKS - 1);

    sfx_state_t        state_q, state_d;
    sfx_id_t           id_q, id_d, new_id;
    logic [PW-1:0]     presc_q;
    logic [MS_W-1:0]   ms_q, cur_dur;
    logic [BEEP_W-1:0] beep_q, beep_d;
    logic              start_q, crash_q, finish_q;
    logic              seq_start, enter_on, clr_cnt, phase_done, last_beep;
    logic              pass_q, pass_d, aud_q, aud_d;
    logic              tone, tone_run;
    logic [TW:0]       half_period;

    // State, counters, edge history and registered output sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            id_q     <= SFX_NONE;
            presc_q  <= '0;
            ms_q     <= '0;
            beep_q   <= '0;
            start_q  <= 1'b0;
            crash_q  <= 1'b0;
            finish_q <= 1'b0;
            pass_q   <= 1'b0;
            aud_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            beep_q   <= beep_d;
            start_q  <= start_en;
            crash_q  <= crash_en;
            finish_q <= finish_en;
            pass_q   <= pass_d;
            aud_q    <= aud_d;
            if (clr_cnt) begin
                presc_q <= '0;
                ms_q    <= '0;
            end else if (state_q != ST_IDLE) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= '0;
                    ms_q    <= ms_q + MS_W'(1);
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

    // Next-state: numeric sfx_id order doubles as priority order.
    always_comb begin
        if (crash_en & ~crash_q)
            new_id = SFX_CRASH;
        else if (finish_en & ~finish_q)
            new_id = SFX_FINISH;
        else if (start_en & ~start_q)
            new_id = SFX_START;
        else
            new_id = SFX_NONE;

        cur_dur    = (state_q == ST_OFF) ? off_ms_of(id_q) : on_ms_of(id_q);
        phase_done = (state_q != ST_IDLE) && (presc_q == PRESC_LAST) &&
                     (ms_q == cur_dur - MS_W'(1));
        last_beep  = ((beep_q + BEEP_W'(1)) == beeps_of(id_q));

        state_d   = state_q;
        id_d      = id_q;
        beep_d    = beep_q;
        seq_start = 1'b0;
        enter_on  = 1'b0;
        clr_cnt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (new_id != SFX_NONE)
                    seq_start = 1'b1;
            end
            ST_ON: begin
                if (new_id > id_q) begin
                    seq_start = 1'b1;
                end else if (phase_done) begin
                    clr_cnt = 1'b1;
                    if (last_beep) begin
                        if (new_id != SFX_NONE) begin
                            seq_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            id_d    = SFX_NONE;
                            beep_d  = '0;
                        end
                    end else begin
                        state_d = ST_OFF;
                        beep_d  = beep_q + BEEP_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (new_id > id_q) begin
                    seq_start = 1'b1;
                end else if (phase_done) begin
                    state_d  = ST_ON;
                    enter_on = 1'b1;
                    clr_cnt  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = SFX_NONE;
                beep_d  = '0;
            end
        endcase

        if (seq_start) begin
            state_d  = ST_ON;
            id_d     = new_id;
            beep_d   = '0;
            enter_on = 1'b1;
            clr_cnt  = 1'b1;
        end
    end

    // Output sources for the next cycle.
    always_comb begin
        pass_d   = (state_d == ST_IDLE) ? (song_pwm & ~pause) : 1'b0;
        aud_d    = (state_d == ST_IDLE) ? (song_aud_on & ~pause) : 1'b1;
        tone_run = (state_d == ST_ON) && !enter_on;
        case (id_d)
            SFX_START:  half_period = (TW+1)'(HP_START);
            SFX_FINISH: half_period = (TW+1)'(HP_FINISH);
            SFX_CRASH:  half_period = (TW+1)'(HP_CRASH);
            default:    half_period = (TW+1)'(HP_MAX);
        endcase
    end

    sfx_tone_gen #(
        .CNT_W (TW)
    ) u_tone (
        .clk         (clk),
        .reset       (reset),
        .restart     (enter_on),
        .run         (tone_run),
        .half_period (half_period),
        .tone        (tone)
    );

    // Tone flop drives pwm only while ON; otherwise the passthrough/OFF flop does.
    assign pwm      = (state_q == ST_ON) ? tone : pass_q;
    assign aud_on   = aud_q;
    assign sfx_busy = (state_q != ST_IDLE);
    assign sfx_id   = id_q;

endmodule
